// File: rtl/eeg_dat_dec.sv
// eeg_dat_dec: decodes input-buffer byte packets into config writes/start pulses and packs data bytes into words
module eeg_dat_dec #(
    parameter int CHIP_DAT_DW = 8,
    parameter int WORD_BYTES  = 4,
    parameter int CFG_AW      = 4,
    parameter int CFG_DW      = 2 * CHIP_DAT_DW
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ACC_DAT_VLD,
    input  logic                              ACC_DAT_LST,
    output logic                              ACC_DAT_RDY,
    input  logic [CHIP_DAT_DW-1:0]            ACC_DAT_DAT,
    input  logic                              ACC_DAT_CMD,
    output logic                              WRD_DAT_VLD,
    output logic                              WRD_DAT_LST,
    input  logic                              WRD_DAT_RDY,
    output logic [WORD_BYTES*CHIP_DAT_DW-1:0] WRD_DAT_DAT,
    output logic                              CFG_WEN,
    output logic [CFG_AW-1:0]                 CFG_ADR,
    output logic [CFG_DW-1:0]                 CFG_DAT,
    output logic                              CFG_STA,
    output logic                              DEC_ERR
);
    localparam int WW = WORD_BYTES * CHIP_DAT_DW;
    localparam int IW = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {IDLE, CHI, CLO, DATA, SKIP} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [WW-1:0]          acc_q, acc_d, fill;
    logic [WW-1:0]          wrd_dat_q, wrd_dat_d;
    logic                   wrd_vld_q, wrd_vld_d, wrd_lst_q, wrd_lst_d;
    logic                   cfg_wen_q, cfg_wen_d, cfg_sta_q, cfg_sta_d;
    logic [CFG_AW-1:0]      cfg_adr_q, cfg_adr_d, adr_q, adr_d;
    logic [CFG_DW-1:0]      cfg_dat_q, cfg_dat_d;
    logic [CHIP_DAT_DW-1:0] hi_q, hi_d;
    logic                   err_q, err_d;
    logic                   xfer, is_dat;
    logic [3:0]             op;

    // A full, undrained output word freezes intake in every state
    assign ACC_DAT_RDY = !(wrd_vld_q && !WRD_DAT_RDY);
    assign xfer        = ACC_DAT_VLD && ACC_DAT_RDY;
    assign is_dat      = (state_q == IDLE && !ACC_DAT_CMD) || state_q == DATA;
    assign op          = ACC_DAT_DAT[CHIP_DAT_DW-1 -: 4];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        wrd_dat_d = wrd_dat_q;
        wrd_lst_d = wrd_lst_q;
        wrd_vld_d = wrd_vld_q && !WRD_DAT_RDY;
        cfg_wen_d = 1'b0;
        cfg_sta_d = 1'b0;
        cfg_adr_d = cfg_adr_q;
        cfg_dat_d = cfg_dat_q;
        adr_d     = adr_q;
        hi_d      = hi_q;
        err_d     = err_q;
        fill      = acc_q;
        fill[idx_q*CHIP_DAT_DW +: CHIP_DAT_DW] = ACC_DAT_DAT;
        if (xfer && is_dat) begin
            if (ACC_DAT_LST || idx_q == IW'(WORD_BYTES - 1)) begin
                wrd_dat_d = fill;
                wrd_lst_d = ACC_DAT_LST;
                wrd_vld_d = 1'b1;
                acc_d     = '0;
                idx_d     = '0;
            end else begin
                acc_d = fill;
                idx_d = idx_q + 1'b1;
            end
            state_d = ACC_DAT_LST ? IDLE : DATA;
        end else if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (op == 4'd1 && !ACC_DAT_LST) begin
                        state_d = CHI;
                        adr_d   = ACC_DAT_DAT[CFG_AW-1:0];
                    end else if (op == 4'd2 && ACC_DAT_LST) begin
                        cfg_sta_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ACC_DAT_LST ? IDLE : SKIP;
                    end
                end
                CHI: begin
                    hi_d    = ACC_DAT_DAT;
                    err_d   = err_q || ACC_DAT_LST;
                    state_d = ACC_DAT_LST ? IDLE : CLO;
                end
                CLO: begin
                    if (ACC_DAT_LST) begin
                        cfg_wen_d = 1'b1;
                        cfg_adr_d = adr_q;
                        cfg_dat_d = {hi_q, ACC_DAT_DAT};
                        state_d   = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                SKIP:    state_d = ACC_DAT_LST ? IDLE : SKIP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            wrd_dat_q <= '0;
            wrd_vld_q <= 1'b0;
            wrd_lst_q <= 1'b0;
            cfg_wen_q <= 1'b0;
            cfg_sta_q <= 1'b0;
            cfg_adr_q <= '0;
            cfg_dat_q <= '0;
            adr_q     <= '0;
            hi_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            wrd_dat_q <= wrd_dat_d;
            wrd_vld_q <= wrd_vld_d;
            wrd_lst_q <= wrd_lst_d;
            cfg_wen_q <= cfg_wen_d;
            cfg_sta_q <= cfg_sta_d;
            cfg_adr_q <= cfg_adr_d;
            cfg_dat_q <= cfg_dat_d;
            adr_q     <= adr_d;
            hi_q      <= hi_d;
            err_q     <= err_d;
        end
    end

    assign WRD_DAT_VLD = wrd_vld_q;
    assign WRD_DAT_LST = wrd_lst_q;
    assign WRD_DAT_DAT = wrd_dat_q;
    assign CFG_WEN     = cfg_wen_q;
    assign CFG_STA     = cfg_sta_q;
    assign CFG_ADR     = cfg_adr_q;
    assign CFG_DAT     = cfg_dat_q;
    assign DEC_ERR     = err_q;
endmodule

// File: tb/tb_eeg_dat_dec.sv
// tb_eeg_dat_dec: directed checks of command decode, word packing, backpressure and reset
module tb_eeg_dat_dec;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ACC_DAT_VLD = 1'b0, ACC_DAT_LST = 1'b0, ACC_DAT_CMD = 1'b0;
    logic        ACC_DAT_RDY;
    logic [7:0]  ACC_DAT_DAT = '0;
    logic        WRD_DAT_VLD, WRD_DAT_LST;
    logic        WRD_DAT_RDY = 1'b1;
    logic [31:0] WRD_DAT_DAT;
    logic        CFG_WEN, CFG_STA, DEC_ERR;
    logic [3:0]  CFG_ADR;
    logic [15:0] CFG_DAT;

    int          checks = 0, errors = 0;
    int          wen_cnt = 0, sta_cnt = 0, base;
    logic [32:0] wq[$];

    eeg_dat_dec dut (
        .clk(clk), .rst_n(rst_n),
        .ACC_DAT_VLD(ACC_DAT_VLD), .ACC_DAT_LST(ACC_DAT_LST), .ACC_DAT_RDY(ACC_DAT_RDY),
        .ACC_DAT_DAT(ACC_DAT_DAT), .ACC_DAT_CMD(ACC_DAT_CMD),
        .WRD_DAT_VLD(WRD_DAT_VLD), .WRD_DAT_LST(WRD_DAT_LST), .WRD_DAT_RDY(WRD_DAT_RDY),
        .WRD_DAT_DAT(WRD_DAT_DAT),
        .CFG_WEN(CFG_WEN), .CFG_ADR(CFG_ADR), .CFG_DAT(CFG_DAT),
        .CFG_STA(CFG_STA), .DEC_ERR(DEC_ERR)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so negedge values match the next edge's handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (WRD_DAT_VLD && WRD_DAT_RDY) wq.push_back({WRD_DAT_LST, WRD_DAT_DAT});
            if (CFG_WEN) wen_cnt++;
            if (CFG_STA) sta_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic c, input logic l);
        int n = 0;
        ACC_DAT_DAT = b;
        ACC_DAT_CMD = c;
        ACC_DAT_LST = l;
        ACC_DAT_VLD = 1'b1;
        forever begin
            @(negedge clk);
            if (ACC_DAT_RDY) break;
            if (++n > 100) begin
                chk("send_tmo", ACC_DAT_RDY, 1);
                break;
            end
        end
        @(posedge clk);
        #1 ACC_DAT_VLD = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        @(negedge clk);
        chk("rst_rdy", ACC_DAT_RDY, 1);
        chk("rst_wvld", WRD_DAT_VLD, 0);
        chk("rst_wdat", WRD_DAT_DAT, 0);
        chk("rst_str", {CFG_WEN, CFG_STA, DEC_ERR}, 0);
        chk("rst_cfg", {CFG_ADR, CFG_DAT}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        send(8'h13, 1, 0);
        send(8'hAB, 0, 0);
        send(8'hCD, 0, 1);
        @(negedge clk);
        chk("wen_hi", CFG_WEN, 1);
        chk("wr_adr", CFG_ADR, 4'h3);
        chk("wr_dat", CFG_DAT, 16'hABCD);
        @(negedge clk);
        chk("wen_lo", CFG_WEN, 0);
        idle(2);
        chk("wen_cnt", wen_cnt, 1);
        chk("wr_err", DEC_ERR, 0);
        chk("wr_hold", CFG_DAT, 16'hABCD);

        base = wq.size();
        for (int i = 0; i < 8; i++) send(8'(i + 1), 0, i == 7);
        idle(3);
        chk("dat_n", wq.size() - base, 2);
        chk("dat_w0", wq[base], {1'b0, 32'h04030201});
        chk("dat_w1", wq[base+1], {1'b1, 32'h08070605});

        base = wq.size();
        send(8'h11, 0, 0);
        send(8'h22, 0, 0);
        send(8'h33, 0, 1);
        send(8'h5A, 0, 1);
        idle(3);
        chk("part_n", wq.size() - base, 2);
        chk("part_w", wq[base], {1'b1, 32'h00332211});
        chk("one_w", wq[base+1], {1'b1, 32'h0000005A});

        base = wq.size();
        WRD_DAT_RDY = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(8'(8'h21 + i), 0, i == 7);
            begin
                repeat (10) @(negedge clk);
                chk("bp_rdy", ACC_DAT_RDY, 0);
                chk("bp_wvld", WRD_DAT_VLD, 1);
                chk("bp_hold", WRD_DAT_DAT, 32'h24232221);
                @(posedge clk);
                #1 WRD_DAT_RDY = 1'b1;
            end
        join
        idle(3);
        chk("bp_n", wq.size() - base, 2);
        chk("bp_w0", wq[base], {1'b0, 32'h24232221});
        chk("bp_w1", wq[base+1], {1'b1, 32'h28272625});

        base = wq.size();
        send(8'h50, 1, 0);
        send(8'h00, 0, 1);
        idle(2);
        chk("err_set", DEC_ERR, 1);
        chk("err_nostr", {wen_cnt[7:0], sta_cnt[7:0]}, {8'd1, 8'd0});
        chk("err_nowrd", wq.size() - base, 0);
        send(8'h20, 1, 1);
        @(negedge clk);
        chk("sta_hi", CFG_STA, 1);
        idle(2);
        chk("sta_cnt", sta_cnt, 1);
        chk("err_stk", DEC_ERR, 1);
        send(8'h14, 1, 1);
        idle(2);
        chk("wr_lst_err", {DEC_ERR, wen_cnt[7:0]}, {1'b1, 8'd1});

        base = wq.size();
        send(8'h77, 0, 0);
        send(8'h88, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_rdy", ACC_DAT_RDY, 1);
        chk("mrst_out", {WRD_DAT_VLD, CFG_WEN, CFG_STA, DEC_ERR}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) send(8'(8'hA1 + i), 0, i == 3);
        idle(3);
        chk("mrst_n", wq.size() - base, 1);
        chk("mrst_w", wq[base], {1'b1, 32'hA4A3A2A1});
        chk("mrst_str", {wen_cnt[7:0], sta_cnt[7:0]}, {8'd1, 8'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eeg_dat_dec.md
# eeg_dat_dec

Stream decoder directly downstream of the chip input buffer's accelerator-side data port. It consumes the buffered byte stream (data byte, command flag, last flag, valid/ready), decodes command packets into configuration-register writes and start pulses, and packs data bytes into wide words for the accelerator core. It is the only consumer of the input buffer's `ACC_DAT_*` port.

## Interface
- `CHIP_DAT_DW`, 8, input byte width.
- `WORD_BYTES`, 4, bytes per output word; power of two, 2..8.
- `CFG_AW`, 4, config register address width; must be ≤ `CHIP_DAT_DW`-4.
- `CFG_DW`, 16, config write data width; fixed at 2*`CHIP_DAT_DW`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ACC_DAT_VLD`  in  1  input byte valid.
- `ACC_DAT_LST`  in  1  last byte of packet.
- `ACC_DAT_RDY`  out  1  input ready.
- `ACC_DAT_DAT`  in  `CHIP_DAT_DW`  input byte.
- `ACC_DAT_CMD`  in  1  byte belongs to a command packet.
- `WRD_DAT_VLD`  out  1  packed word valid.
- `WRD_DAT_LST`  out  1  word carries the packet's last byte.
- `WRD_DAT_RDY`  in  1  core accepts word.
- `WRD_DAT_DAT`  out  `WORD_BYTES*CHIP_DAT_DW`  packed word.
- `CFG_WEN`  out  1  one-cycle config write strobe.
- `CFG_ADR`  out  `CFG_AW`  config address.
- `CFG_DAT`  out  `CFG_DW`  config write data.
- `CFG_STA`  out  1  one-cycle start pulse.
- `DEC_ERR`  out  1  sticky protocol-error flag.

## Operation
- Byte transfer when `ACC_DAT_VLD && ACC_DAT_RDY`. Packet type set by `ACC_DAT_CMD` of its first byte; `CMD` on later bytes ignored.
- FSM states: IDLE, CHI, CLO, DATA, SKIP.
- IDLE: CMD=1 byte → opcode = byte[7:4], addr = byte[CFG_AW-1:0].
  - opcode 1 (write) with LST=0 → CHI.
  - opcode 2 (start) with LST=1 → pulse `CFG_STA`, stay IDLE.
  - anything else (unknown opcode, write with LST=1, start with LST=0) → set `DEC_ERR`; → SKIP if LST=0, else IDLE.
  - CMD=0 byte → packed as byte 0 of a word; → DATA (or stays IDLE if LST=1 after emitting a word).
- CHI: byte → `CFG_DAT[15:8]`; LST=1 → error, IDLE; else → CLO.
- CLO: byte → low data; LST=1 → pulse `CFG_WEN`, IDLE; LST=0 → `DEC_ERR`, SKIP.
- SKIP: discard bytes until LST, then IDLE.
- DATA packing: byte k of a word at bits [k*DW +: DW] (first byte = LSBs). Word emitted when byte `WORD_BYTES-1` arrives or LST=1; unfilled upper bytes zero. `WRD_DAT_LST` = LST of final byte. Byte index resets to 0 after each emitted word; → IDLE after LST.
- `DEC_ERR` clears only on reset.

## Timing
- Reset values: all outputs 0 except `ACC_DAT_RDY`=1; FSM IDLE, byte index 0.
- `ACC_DAT_RDY` = 1 in IDLE/CHI/CLO/SKIP except when the output word register is full and not draining (`WRD_DAT_VLD && !WRD_DAT_RDY`); in that case it is 0 in every state, so no byte is consumed while a word is stalled.
- Word latency: `WRD_DAT_VLD` rises the cycle after the completing byte's transfer; holds data until `WRD_DAT_RDY`. Same-cycle drain and new completing byte permitted (back-to-back words every `WORD_BYTES` cycles).
- `CFG_WEN`/`CFG_STA` rise the cycle after the final command byte, high exactly one cycle; `CFG_ADR`/`CFG_DAT` stable from that cycle until the next write.
- Single-byte data packet (LST on first byte): word = {zeros, byte}, LST=1.
- Reset asserted mid-packet: immediate return to reset values; partial word and pending command discarded; no strobes.

## Test plan
- Write: bytes 0x13(CMD),0xAB,0xCD(LST) → one cycle `CFG_WEN`=1, `CFG_ADR`=3, `CFG_DAT`=0xABCD; `DEC_ERR`=0.
- Data: 0x01..0x08 CMD=0, LST on 0x08, `WRD_DAT_RDY`=1 → words 0x04030201 (LST=0), 0x08070605 (LST=1).
- Partial: 0x11,0x22,0x33 (LST on 0x33) → word 0x00332211, LST=1.
- Backpressure: hold `WRD_DAT_RDY`=0 after first word of 8-byte packet → `ACC_DAT_RDY`=0, word stable; release → second word correct, no byte lost.
- Errors: 0x50,0x00(LST) → `DEC_ERR`=1, no strobe, both bytes consumed; then 0x20(LST) → `CFG_STA` pulse, `DEC_ERR` stays 1.
- Reset after two data bytes → outputs 0, `ACC_DAT_RDY`=1; next 4-byte packet yields an uncorrupted word.
